hazard_scoreboard: RTL and testbench

- Parametrised next-generation bypass/hazard controller for the 5-stage pipeline.
- Generates X-stage operand bypass selects, M-stage store-data bypass and load-use stalls.
- Adds a scoreboard for the multi-cycle mult/div unit: it holds dependent instructions in D/X until the result is ready.
- Sits beside the DX/XM/MW latches. It drives the stall/bubble controls and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 183 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Bypass/hazard controller for the 5-stage pipeline. Produces the
//             X-stage operand bypass selects, the M-stage store-data bypass,
//             load-use stalls, and a scoreboard for the multi-cycle mult/div
//             unit. Also keeps a saturating stall-cycle counter.
//  Ports    : clock/resetn        - clock, async active-low reset
//             DX_* / XM_* / MW_*  - pipeline latch fields
//             md_ready            - mult/div result valid
//             perf_clr            - synchronous clear of stall_cycles
//             XAsel/XBsel/MWDsel  - bypass selects (combinational)
//             stall/bubble_XM     - freeze front end / inject nop into XM
//             md_busy/md_rd/md_done/md_timeout - scoreboard status
//             stall_cycles        - saturating stall counter
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_BITS     = 5,
  parameter int SETX_REG     = 30,
  parameter int MULT_TIMEOUT = 40,
  parameter int DIV_TIMEOUT  = 40,
  parameter int CNT_W        = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [REG_BITS-1:0] DX_rs,
  input  logic [REG_BITS-1:0] DX_rt,
  input  logic [REG_BITS-1:0] DX_rd,
  input  logic                DX_useA,
  input  logic                DX_useB,
  input  logic                DX_rtin,
  input  logic                DX_sw,
  input  logic                DX_setx,
  input  logic                DX_we,
  input  logic                DX_md_start,
  input  logic                DX_is_div,
  input  logic [REG_BITS-1:0] XM_rd,
  input  logic                XM_we,
  input  logic                XM_lw,
  input  logic                XM_sw,
  input  logic [REG_BITS-1:0] MW_rd,
  input  logic                MW_we,
  input  logic                md_ready,
  input  logic                perf_clr,
  output logic [1:0]          XAsel,
  output logic [1:0]          XBsel,
  output logic                MWDsel,
  output logic                stall,
  output logic                bubble_XM,
  output logic                md_busy,
  output logic [REG_BITS-1:0] md_rd,
  output logic                md_done,
  output logic                md_timeout,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int c_tmo_max = (MULT_TIMEOUT > DIV_TIMEOUT) ? MULT_TIMEOUT : DIV_TIMEOUT;
  localparam int c_tmo_w   = $clog2(c_tmo_max + 1);
  localparam logic [c_tmo_w-1:0]  c_mult_tmo = c_tmo_w'(MULT_TIMEOUT);
  localparam logic [c_tmo_w-1:0]  c_div_tmo  = c_tmo_w'(DIV_TIMEOUT);
  localparam logic [REG_BITS-1:0] c_setx_reg = REG_BITS'(SETX_REG);
  localparam logic [REG_BITS-1:0] c_zero_reg = '0;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [REG_BITS-1:0] md_rd_q, md_rd_d;
  logic [c_tmo_w-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic                md_done_q, md_done_d;
  logic                md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

  logic [REG_BITS-1:0] w_xa, w_xb;
  logic                w_xa_nz, w_xb_nz, w_rd_nz, w_xm_nz, w_md_nz;
  logic                w_load_stall, w_md_stall, w_stall;

  // Operand register numbers actually read by the DX instruction
  assign w_xa = DX_setx ? c_setx_reg : DX_rs;
  assign w_xb = DX_rtin ? DX_rd : DX_rt;

  // r0 never carries a dependence
  assign w_xa_nz = (w_xa != c_zero_reg);
  assign w_xb_nz = (w_xb != c_zero_reg);
  assign w_rd_nz = (DX_rd != c_zero_reg);
  assign w_xm_nz = (XM_rd != c_zero_reg);
  assign w_md_nz = (md_rd_q != c_zero_reg);

  // Bypass selects: the younger XM result wins over MW
  always_comb begin
    XAsel = 2'd0;
    if (DX_useA && w_xa_nz && XM_we && (w_xa == XM_rd))      XAsel = 2'd1;
    else if (DX_useA && w_xa_nz && MW_we && (w_xa == MW_rd)) XAsel = 2'd2;
    XBsel = 2'd0;
    if (DX_useB && w_xb_nz && XM_we && (w_xb == XM_rd))      XBsel = 2'd1;
    else if (DX_useB && w_xb_nz && MW_we && (w_xb == MW_rd)) XBsel = 2'd2;
  end

  assign MWDsel = XM_sw && w_xm_nz && MW_we && (XM_rd == MW_rd);

  // A store's B operand is picked up by the MWDsel path one stage later,
  // so it does not need to wait for the load.
  assign w_load_stall = XM_lw && XM_we && w_xm_nz &&
                        ((DX_useA && w_xa == XM_rd) ||
                         (DX_useB && w_xb == XM_rd && !DX_sw));

  // Hold anything that would read, or overwrite (WAW), the pending result,
  // and any second mult/div while the unit is occupied.
  assign w_md_stall = (state_q == S_MD_BUSY) &&
                      (DX_md_start ||
                       (DX_useA && w_md_nz && w_xa == md_rd_q) ||
                       (DX_useB && w_md_nz && w_xb == md_rd_q) ||
                       (DX_we   && w_rd_nz && w_md_nz && DX_rd == md_rd_q));

  assign w_stall   = w_load_stall | w_md_stall;
  assign stall     = w_stall;
  assign bubble_XM = w_stall;

  always_comb begin
    state_d        = state_q;
    md_rd_d        = md_rd_q;
    tmo_cnt_d      = tmo_cnt_q;
    md_done_d      = 1'b0;
    md_timeout_d   = md_timeout_q;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      S_IDLE: begin
        if (DX_md_start && !w_stall) begin
          state_d   = S_MD_BUSY;
          md_rd_d   = DX_rd;
          tmo_cnt_d = DX_is_div ? c_div_tmo : c_mult_tmo;
        end
      end
      S_MD_BUSY: begin
        if (md_ready) begin
          state_d   = S_IDLE;
          md_done_d = 1'b1;
        end else if (tmo_cnt_q <= c_tmo_w'(1)) begin
          // Last allowed cycle expired without a result
          state_d      = S_IDLE;
          tmo_cnt_d    = '0;
          md_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - c_tmo_w'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (perf_clr)                         stall_cycles_d = '0;
    else if (w_stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      md_rd_q        <= '0;
      tmo_cnt_q      <= '0;
      md_done_q      <= 1'b0;
      md_timeout_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      md_rd_q        <= md_rd_d;
      tmo_cnt_q      <= tmo_cnt_d;
      md_done_q      <= md_done_d;
      md_timeout_q   <= md_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign md_busy      = (state_q == S_MD_BUSY);
  assign md_rd        = md_rd_q;
  assign md_done      = md_done_q;
  assign md_timeout   = md_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard: directed scenarios
//             with literal expectations, then randomized traffic compared
//             each cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int RB   = 5;
  localparam int SETX = 30;
  localparam int MTO  = 12;
  localparam int DTO  = 9;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          resetn;
  logic [RB-1:0] DX_rs, DX_rt, DX_rd, XM_rd, MW_rd;
  logic          DX_useA, DX_useB, DX_rtin, DX_sw, DX_setx, DX_we;
  logic          DX_md_start, DX_is_div, XM_we, XM_lw, XM_sw, MW_we;
  logic          md_ready, perf_clr;
  logic [1:0]    XAsel, XBsel;
  logic          MWDsel, stall, bubble_XM, md_busy, md_done, md_timeout;
  logic [RB-1:0] md_rd;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_busy, m_done, m_tmo;
  int m_rd, m_left, m_cnt;

  hazard_scoreboard #(
    .REG_BITS(RB), .SETX_REG(SETX), .MULT_TIMEOUT(MTO),
    .DIV_TIMEOUT(DTO), .CNT_W(CW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .DX_rs(DX_rs), .DX_rt(DX_rt), .DX_rd(DX_rd),
    .DX_useA(DX_useA), .DX_useB(DX_useB), .DX_rtin(DX_rtin),
    .DX_sw(DX_sw), .DX_setx(DX_setx), .DX_we(DX_we),
    .DX_md_start(DX_md_start), .DX_is_div(DX_is_div),
    .XM_rd(XM_rd), .XM_we(XM_we), .XM_lw(XM_lw), .XM_sw(XM_sw),
    .MW_rd(MW_rd), .MW_we(MW_we),
    .md_ready(md_ready), .perf_clr(perf_clr),
    .XAsel(XAsel), .XBsel(XBsel), .MWDsel(MWDsel),
    .stall(stall), .bubble_XM(bubble_XM),
    .md_busy(md_busy), .md_rd(md_rd), .md_done(md_done),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    DX_rs = 0; DX_rt = 0; DX_rd = 0; XM_rd = 0; MW_rd = 0;
    DX_useA = 0; DX_useB = 0; DX_rtin = 0; DX_sw = 0; DX_setx = 0; DX_we = 0;
    DX_md_start = 0; DX_is_div = 0; XM_we = 0; XM_lw = 0; XM_sw = 0; MW_we = 0;
    md_ready = 0; perf_clr = 0;
  endtask

  task automatic sync();
    @(posedge clock); #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int bypass(input bit use_op, input int r);
    if (!use_op || r == 0)                return 0;
    if (XM_we && r == int'(XM_rd))        return 1;
    if (MW_we && r == int'(MW_rd))        return 2;
    return 0;
  endfunction

  function automatic int opa();
    return DX_setx ? SETX : int'(DX_rs);
  endfunction

  function automatic int opb();
    return DX_rtin ? int'(DX_rd) : int'(DX_rt);
  endfunction

  function automatic bit exp_stall();
    int a = opa();
    int b = opb();
    bit ld, md;
    ld = XM_lw && XM_we && XM_rd != 0 &&
         ((DX_useA && a == int'(XM_rd)) || (DX_useB && b == int'(XM_rd) && !DX_sw));
    md = m_busy && (DX_md_start ||
         (m_rd != 0 && ((DX_useA && a == m_rd) || (DX_useB && b == m_rd) ||
                        (DX_we && int'(DX_rd) == m_rd))));
    return ld || md;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_tmo = 0; m_rd = 0; m_left = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    bit s = exp_stall();
    m_done = 0;
    if (!m_busy) begin
      if (DX_md_start && !s) begin
        m_busy = 1; m_rd = int'(DX_rd); m_left = DX_is_div ? DTO : MTO;
      end
    end else if (md_ready) begin
      m_busy = 0; m_done = 1;
    end else begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_tmo = 1; end
    end
    if (perf_clr)              m_cnt = 0;
    else if (s && m_cnt < CMAX) m_cnt++;
  endfunction

  task automatic compare_all();
    bit s = exp_stall();
    chk("XAsel", 32'(XAsel), 32'(bypass(DX_useA, opa())));
    chk("XBsel", 32'(XBsel), 32'(bypass(DX_useB, opb())));
    chk("MWDsel", 32'(MWDsel), 32'(XM_sw && MW_we && XM_rd != 0 && XM_rd == MW_rd));
    chk("stall", 32'(stall), 32'(s));
    chk("bubble_XM", 32'(bubble_XM), 32'(s));
    chk("md_busy", 32'(md_busy), 32'(m_busy));
    chk("md_rd", 32'(md_rd), 32'(m_rd));
    chk("md_done", 32'(md_done), 32'(m_done));
    chk("md_timeout", 32'(md_timeout), 32'(m_tmo));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
  endtask

  function automatic logic [RB-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 5'd0;
      1:       return 5'd3;
      2:       return 5'd5;
      3:       return 5'd7;
      4:       return 5'd9;
      default: return 5'd30;
    endcase
  endfunction

  initial begin
    int cnt;
    clr_in();
    resetn = 0;
    #2;
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    chk("rst_md_timeout", 32'(md_timeout), 0);
    sync(); sync();
    resetn = 1;

    // bypass priorities
    sync();
    XM_rd = 5; XM_we = 1; MW_rd = 5; MW_we = 1; DX_rs = 5; DX_useA = 1;
    #1 chk("xa_xm", 32'(XAsel), 1);
    XM_we = 0;
    #1 chk("xa_mw", 32'(XAsel), 2);
    DX_rs = 0;
    #1 chk("xa_r0", 32'(XAsel), 0);
    DX_setx = 1; MW_rd = 30;
    #1 chk("xa_setx", 32'(XAsel), 2);

    // load-use
    sync(); clr_in();
    XM_rd = 7; XM_lw = 1; XM_we = 1; DX_rt = 7; DX_useB = 1;
    #1 chk("ld_stall", 32'(stall), 1);
    chk("ld_bubble", 32'(bubble_XM), 1);
    DX_sw = 1;
    #1 chk("ld_store_nostall", 32'(stall), 0);
    XM_lw = 0; XM_sw = 1; MW_rd = 7; MW_we = 1;
    #1 chk("mwdsel", 32'(MWDsel), 1);

    // mult with result after 6 busy cycles
    sync(); clr_in(); perf_clr = 1;
    sync(); perf_clr = 0;
    DX_md_start = 1; DX_rd = 9;
    sync(); clr_in();
    chk("mul_busy", 32'(md_busy), 1);
    chk("mul_rd", 32'(md_rd), 9);
    DX_rs = 9; DX_useA = 1; DX_rd = 10; DX_we = 1;
    for (int k = 1; k <= 6; k++) begin
      chk("mul_dep_stall", 32'(stall), 1);
      if (k == 6) md_ready = 1;
      sync();
    end
    md_ready = 0;
    chk("mul_done", 32'(md_done), 1);
    chk("mul_busy_off", 32'(md_busy), 0);
    chk("mul_done_nostall", 32'(stall), 0);
    chk("mul_cycles", 32'(stall_cycles), 6);
    sync();
    chk("mul_done_pulse", 32'(md_done), 0);

    // divide timeout
    clr_in(); DX_md_start = 1; DX_is_div = 1; DX_rd = 3;
    sync(); clr_in();
    cnt = 0;
    while (md_busy && cnt < 100) begin cnt++; sync(); end
    chk("div_busy_len", 32'(cnt), DTO);
    chk("div_timeout", 32'(md_timeout), 1);
    chk("div_no_done", 32'(md_done), 0);
    sync(); sync();
    chk("div_timeout_sticky", 32'(md_timeout), 1);

    // async reset mid busy
    DX_md_start = 1; DX_rd = 9;
    sync(); clr_in(); DX_rs = 9; DX_useA = 1;
    repeat (3) sync();
    chk("pre_rst_cycles", 32'(stall_cycles), 9);
    #1 resetn = 0;
    #1;
    chk("arst_busy", 32'(md_busy), 0);
    chk("arst_rd", 32'(md_rd), 0);
    chk("arst_cycles", 32'(stall_cycles), 0);
    chk("arst_timeout", 32'(md_timeout), 0);
    chk("arst_stall", 32'(stall), 0);
    sync(); resetn = 1;

    // saturation and clear priority
    clr_in(); XM_rd = 7; XM_lw = 1; XM_we = 1; DX_rs = 7; DX_useA = 1;
    repeat (40) sync();
    chk("sat_cycles", 32'(stall_cycles), CMAX);
    perf_clr = 1;
    sync();
    chk("clr_prio", 32'(stall_cycles), 0);

    // randomized run against the model
    clr_in(); resetn = 0;
    sync(); resetn = 1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      DX_rs = pick(); DX_rt = pick(); DX_rd = pick();
      XM_rd = pick(); MW_rd = pick();
      DX_useA = 1'($urandom_range(0, 1)); DX_useB = 1'($urandom_range(0, 1));
      DX_rtin = ($urandom_range(0, 3) == 0); DX_sw = ($urandom_range(0, 3) == 0);
      DX_setx = ($urandom_range(0, 5) == 0); DX_we = 1'($urandom_range(0, 1));
      DX_md_start = ($urandom_range(0, 5) == 0); DX_is_div = 1'($urandom_range(0, 1));
      XM_we = 1'($urandom_range(0, 1)); XM_lw = ($urandom_range(0, 2) == 0);
      XM_sw = ($urandom_range(0, 3) == 0); MW_we = 1'($urandom_range(0, 1));
      md_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      perf_clr = ($urandom_range(0, 59) == 0);
      resetn = ($urandom_range(0, 199) != 0);
      if (!resetn) model_reset();
      #3;
      compare_all();
      if (resetn) model_step();
      sync();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
